// File: rtl/ddma_regs_pkg.sv
// Shared definitions for the DDMA MMIO register block: register offsets,
// command FSM states and the byte-swap helper used on the CPU data path.
package ddma_regs_pkg;

   localparam logic [2:0] OFF_ID     = 3'd0;
   localparam logic [2:0] OFF_DEST   = 3'd1;
   localparam logic [2:0] OFF_ADDR   = 3'd2;
   localparam logic [2:0] OFF_SIZE   = 3'd3;
   localparam logic [2:0] OFF_CMD    = 3'd4;
   localparam logic [2:0] OFF_STATUS = 3'd5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      BUSY = 2'd2
   } state_t;

   function automatic logic [31:0] bswap32(input logic [31:0] v);
      return {v[7:0], v[15:8], v[23:16], v[31:24]};
   endfunction

endpackage

// File: rtl/ddma_mmio_regs.sv
// CPU-facing register file for the DDMA engine: captures dest/addr/size,
// issues a req/ack start command, tracks completion and holds sticky IRQs.
//
// state | meaning
// IDLE  | no transfer; DEST/ADDR/SIZE/CMD writable
// REQ   | cmd_req_out asserted, waiting for cmd_ack_in
// BUSY  | DDMA accepted; waiting for send_done_in
module ddma_mmio_regs
   import ddma_regs_pkg::*;
#(
   parameter int unsigned MEMORY_WIDTH = 32,
   parameter logic [31:0] ADDRESS      = 32'h0,
   parameter logic [31:0] BASE_ADDR    = 32'h2000_0000
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [MEMORY_WIDTH-1:0] addr_in,
   input  logic [MEMORY_WIDTH-1:0] data_in,
   input  logic [3:0]              wb_in,
   output logic [MEMORY_WIDTH-1:0] data_out,
   output logic                    err_out,
   output logic [MEMORY_WIDTH-1:0] dest_out,
   output logic [MEMORY_WIDTH-1:0] addr_out,
   output logic [MEMORY_WIDTH-1:0] size_out,
   output logic                    cmd_req_out,
   input  logic                    cmd_ack_in,
   input  logic                    send_done_in,
   input  logic                    recv_irq_in,
   input  logic [2:0]              state_send_in,
   input  logic [2:0]              state_recv_in,
   output logic                    irq_send_out,
   output logic                    irq_recv_out
);

   state_t      state_q, state_d;
   logic [31:0] dest_q, dest_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] size_q, size_d;
   logic [31:0] data_q, data_d;
   logic        err_q, err_d;
   logic        irq_send_q, irq_send_d;
   logic        irq_recv_q, irq_recv_d;

   logic        hit;
   logic [2:0]  off;
   logic        wr_full;
   logic        wr_part;
   logic        idle;
   logic        cfg_off;
   logic [31:0] wr_data;
   logic        cmd_write;
   logic        cmd_go;
   logic        cmd_zero_size;
   logic        unused_addr_lsb;

   assign hit     = (addr_in[31:5] == BASE_ADDR[31:5]);
   assign off     = addr_in[4:2];
   assign wr_full = hit && (wb_in == 4'hF);
   assign wr_part = hit && (wb_in != 4'h0) && (wb_in != 4'hF);
   assign idle    = (state_q == IDLE);
   assign cfg_off = (off >= OFF_DEST) && (off <= OFF_CMD);
   assign wr_data = bswap32(data_in);

   assign cmd_write     = wr_full && (off == OFF_CMD) && idle && (wr_data != 32'h0);
   assign cmd_go        = cmd_write && (size_q != 32'h0);
   assign cmd_zero_size = cmd_write && (size_q == 32'h0);

   assign unused_addr_lsb = ^addr_in[1:0];

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (cmd_go)       state_d = REQ;
         REQ:     if (cmd_ack_in)   state_d = BUSY;
         BUSY:    if (send_done_in) state_d = IDLE;
         default:                   state_d = IDLE;
      endcase
   end

   always_comb begin
      cmd_req_out = (state_q == REQ);
   end

   always_comb begin
      dest_d     = dest_q;
      addr_d     = addr_q;
      size_d     = size_q;
      irq_send_d = irq_send_q;
      irq_recv_d = irq_recv_q;
      data_d     = 32'h0;

      if (wr_full && idle) begin
         case (off)
            OFF_DEST: dest_d = wr_data;
            OFF_ADDR: addr_d = wr_data;
            OFF_SIZE: size_d = wr_data;
            default:  ;
         endcase
      end

      // Clear first so a same-cycle set overrides the W1C.
      if (wr_full && (off == OFF_STATUS)) begin
         if (data_in[31]) irq_send_d = 1'b0;
         if (data_in[30]) irq_recv_d = 1'b0;
      end
      if ((state_q == BUSY) && send_done_in) irq_send_d = 1'b1;
      if (recv_irq_in)                        irq_recv_d = 1'b1;

      err_d = wr_part
            || (hit && (off[2:1] == 2'b11))
            || (wr_full && !idle && cfg_off)
            || cmd_zero_size;

      if (hit) begin
         case (off)
            OFF_ID:     data_d = bswap32(ADDRESS);
            OFF_DEST:   data_d = bswap32(dest_q);
            OFF_ADDR:   data_d = bswap32(addr_q);
            OFF_SIZE:   data_d = bswap32(size_q);
            OFF_CMD:    data_d = bswap32({31'b0, !idle});
            OFF_STATUS: data_d = {irq_send_q, irq_recv_q, state_send_in, state_recv_in, 24'h0};
            default:    data_d = 32'h0;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         dest_q     <= 32'h0;
         addr_q     <= 32'h0;
         size_q     <= 32'h0;
         data_q     <= 32'h0;
         err_q      <= 1'b0;
         irq_send_q <= 1'b0;
         irq_recv_q <= 1'b0;
      end else begin
         dest_q     <= dest_d;
         addr_q     <= addr_d;
         size_q     <= size_d;
         data_q     <= data_d;
         err_q      <= err_d;
         irq_send_q <= irq_send_d;
         irq_recv_q <= irq_recv_d;
      end
   end

   assign data_out     = data_q;
   assign err_out      = err_q;
   assign dest_out     = dest_q;
   assign addr_out     = addr_q;
   assign size_out     = size_q;
   assign irq_send_out = irq_send_q;
   assign irq_recv_out = irq_recv_q;

endmodule
